// File: rtl/alarm_pkg.sv
// Package alarm_pkg
// Shared definitions for the alarm path. These include the state encoding, the
// bit positions of the BCD fields in the packed 13-bit time, the wrap limits,
// the packed time type (also used by the alarm register and the comparator),
// and a legality check for captured times.
package alarm_pkg;

    // Edit-session state encoding
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] EDIT_HOUR = 2'd1;
    localparam logic [1:0] EDIT_MIN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = IDLE,
        S_EDIT_HOUR = EDIT_HOUR,
        S_EDIT_MIN  = EDIT_MIN
    } state_e;

    // LSB positions of each BCD digit in the packed time {Ht, Hu, Mt, Mu}
    localparam int HT_LSB = 11;
    localparam int HU_LSB = 7;
    localparam int MT_LSB = 4;
    localparam int MU_LSB = 0;

    localparam logic [6:0] MAX_HOUR = 7'd23;
    localparam logic [6:0] MAX_MIN  = 7'd59;

    typedef struct packed {
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
    } bcd_time_t;

    // A time is legal when every digit is in range and hours do not exceed 23.
    function automatic logic is_valid_time(input bcd_time_t t);
        logic ok;
        ok = (t.ht <= 2'd2) && (t.hu <= 4'd9) && (t.mt <= 3'd5) && (t.mu <= 4'd9)
             && !((t.ht == 2'd2) && (t.hu > 4'd3));
        return ok;
    endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Module bcd2_inc
// A combinational two-digit BCD incrementer with a wrap limit.
//   tens_in   [TENS_W-1:0]  tens digit of the current value
//   units_in  [3:0]         units digit of the current value
//   max_val   [6:0]         binary value at which the next increment wraps to 00
//   tens_out  [TENS_W-1:0]  tens digit of the incremented value
//   units_out [3:0]         units digit of the incremented value
module bcd2_inc #(
    parameter int TENS_W = 3
) (
    input  logic [TENS_W-1:0] tens_in,
    input  logic [3:0]        units_in,
    input  logic [6:0]        max_val,
    output logic [TENS_W-1:0] tens_out,
    output logic [3:0]        units_out
);

    logic [6:0] value;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
        value     = 7'(tens_in) * 7'd10 + 7'(units_in);
        tens_out  = tens_in;
        units_out = units_in + 4'd1;
        // The wrap is judged on the combined value so that hours wrap at 23, not at x9.
        if (value >= max_val) begin
            tens_out  = '0;
            units_out = '0;
        end else if (units_in >= 4'd9) begin
            tens_out  = tens_in + TENS_W'(1);
            units_out = '0;
        end
    end

endmodule

// File: rtl/alarm_time_setter.sv
// Module alarm_time_setter
// This block edits a 24-hour BCD HH:MM alarm time using two debounced buttons.
// Each edit session starts from the alarm register's current value. It steps
// through the hour and minute fields, and a write strobe commits the result.
// Optional build macro: AUTO_REPEAT_EN. When it is defined, holding inc
// auto-repeats the increment.
//   clock      system clock, rising edge
//   clear      synchronous active-high reset
//   mode_btn   debounced level; a rising edge advances the state
//   inc_btn    debounced level; a rising edge increments the active field
//   time_in    [12:0] register Q feedback, {Ht[12:11], Hu[10:7], Mt[6:4], Mu[3:0]}
//   time_out   [12:0] working value to register D (registered)
//   load       one-cycle register write enable (registered)
//   edit_hour  high while editing hours (registered)
//   edit_min   high while editing minutes (registered)
module alarm_time_setter
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic [12:0] time_in,
    output logic [12:0] time_out,
    output logic        load,
    output logic        edit_hour,
    output logic        edit_min
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // The auto-repeat reload scheme needs a period no longer than delay+1.
    if (TIMEOUT_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY + 1) begin : g_bad_cfg
        $error("alarm_time_setter: unsupported TIMEOUT_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    state_e          state_q, state_d;
    logic [12:0]     time_q, time_d;
    logic            load_q, load_d;
    logic            edit_hour_q, edit_hour_d;
    logic            edit_min_q, edit_min_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mode_prev_q, mode_prev_d;
    logic            inc_prev_q, inc_prev_d;

    logic            mode_edge, inc_edge, rep_fire, bump, activity;
    logic [1:0]      hour_tens_nx;
    logic [3:0]      hour_units_nx;
    logic [2:0]      min_tens_nx;
    logic [3:0]      min_units_nx;

    bcd2_inc #(.TENS_W(2)) u_hour_inc (
        .tens_in   (time_q[HT_LSB +: 2]),
        .units_in  (time_q[HU_LSB +: 4]),
        .max_val   (MAX_HOUR),
        .tens_out  (hour_tens_nx),
        .units_out (hour_units_nx)
    );

    bcd2_inc #(.TENS_W(3)) u_min_inc (
        .tens_in   (time_q[MT_LSB +: 3]),
        .units_in  (time_q[MU_LSB +: 4]),
        .max_val   (MAX_MIN),
        .tens_out  (min_tens_nx),
        .units_out (min_units_nx)
    );

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 2);
    localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
    // After a repeat the counter restarts so that it reaches HOLD_FIRE again after REPEAT_PERIOD cycles.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY + 1 - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        rep_fire   = 1'b0;
        hold_cnt_d = '0;
        if (inc_btn && (state_q != S_IDLE)) begin
            if (hold_cnt_q == HOLD_FIRE) begin
                rep_fire   = 1'b1;
                hold_cnt_d = HOLD_RELOAD;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end
        // Leaving the state (mode edge or timeout) restarts the hold count.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        mode_edge   = mode_btn & ~mode_prev_q;
        inc_edge    = inc_btn & ~inc_prev_q;
        // If mode and inc arrive together, mode takes priority and the increment is dropped.
        bump        = (inc_edge | rep_fire) & ~mode_edge;
        mode_prev_d = mode_btn;
        inc_prev_d  = inc_btn;

        state_d = state_q;
        time_d  = time_q;
        load_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mode_edge) begin
                    state_d = S_EDIT_HOUR;
                    time_d  = is_valid_time(bcd_time_t'(time_in)) ? time_in : 13'b0;
                end
            end
            S_EDIT_HOUR: begin
                if (mode_edge) begin
                    state_d = S_EDIT_MIN;
                end else if (bump) begin
                    time_d[HT_LSB +: 2] = hour_tens_nx;
                    time_d[HU_LSB +: 4] = hour_units_nx;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_EDIT_MIN: begin
                if (mode_edge) begin
                    state_d = S_IDLE;
                    load_d  = 1'b1;
                end else if (bump) begin
                    time_d[MT_LSB +: 3] = min_tens_nx;
                    time_d[MU_LSB +: 4] = min_units_nx;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        activity   = mode_edge | inc_edge | rep_fire | (state_d != state_q);
        to_cnt_d   = (activity || (state_q == S_IDLE)) ? '0 : to_cnt_q + TO_W'(1);
        edit_hour_d = (state_d == S_EDIT_HOUR);
        edit_min_d  = (state_d == S_EDIT_MIN);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state_q     <= S_IDLE;
            time_q      <= '0;
            load_q      <= 1'b0;
            edit_hour_q <= 1'b0;
            edit_min_q  <= 1'b0;
            to_cnt_q    <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            load_q      <= load_d;
            edit_hour_q <= edit_hour_d;
            edit_min_q  <= edit_min_d;
            to_cnt_q    <= to_cnt_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    assign time_out  = time_q;
    assign load      = load_q;
    assign edit_hour = edit_hour_q;
    assign edit_min  = edit_min_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed testbench for alarm_time_setter. It uses TIMEOUT_CYCLES=20,
// REPEAT_DELAY=5 and REPEAT_PERIOD=2.
module tb_alarm_time_setter;

    logic        clock = 1'b0;
    logic        clear;
    logic        mode_btn;
    logic        inc_btn;
    logic [12:0] time_in;
    logic [12:0] time_out;
    logic        load;
    logic        edit_hour;
    logic        edit_min;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int load_count    = 0;
    int load_base;

    alarm_time_setter #(
        .TIMEOUT_CYCLES (20),
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .time_in   (time_in),
        .time_out  (time_out),
        .load      (load),
        .edit_hour (edit_hour),
        .edit_min  (edit_min)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (load === 1'b1) load_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; tick();
        mode_btn = 1'b0; tick();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1; tick();
            inc_btn = 1'b0; tick();
        end
    endtask

    task automatic do_clear();
        clear = 1'b1; tick();
        clear = 1'b0; tick();
    endtask

    initial begin
        clear    = 1'b1;
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        time_in  = 13'b01_0010_011_0100;   // 12:34

        // Clear held for two cycles while the buttons are active.
        ticks(2);
        check("rst_time", time_out, 13'b0);
        check("rst_load", load, 1'b0);
        check("rst_flags", {edit_hour, edit_min}, 2'b00);
        clear = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        tick();
        press_inc(2);
        check("idle_inc_time", time_out, 13'b0);
        check("idle_inc_flags", {edit_hour, edit_min}, 2'b00);

        // 12:34 -> 15:04 with a single commit
        load_base = load_count;
        press_mode();
        check("cap_1234", time_out, 13'b01_0010_011_0100);
        check("cap_flags", {edit_hour, edit_min}, 2'b10);
        press_inc(3);
        check("hour_15", time_out, 13'b01_0101_011_0100);
        press_mode();
        check("min_flags", {edit_hour, edit_min}, 2'b01);
        press_inc(30);
        check("min_04", time_out, 13'b01_0101_000_0100);
        check("no_early_load", load_count - load_base, 0);
        mode_btn = 1'b1; tick();
        check("commit_load", load, 1'b1);
        check("commit_time", time_out, 13'b01_0101_000_0100);
        check("commit_flags", {edit_hour, edit_min}, 2'b00);
        mode_btn = 1'b0; tick();
        check("load_one_cycle", load, 1'b0);
        check("load_pulses", load_count - load_base, 1);
        check("hold_after", time_out, 13'b01_0101_000_0100);

        // 23:59 wraps to 00:59, then to 00:00 with no carry into the hours
        time_in   = 13'b10_0011_101_1001;
        load_base = load_count;
        press_mode();
        press_inc(1);
        check("hour_wrap", time_out, 13'b00_0000_101_1001);
        press_mode();
        press_inc(1);
        check("min_wrap", time_out, 13'b0);
        press_mode();
        check("wrap_load", load_count - load_base, 1);
        check("wrap_time", time_out, 13'b0);

        // An invalid capture clears the working value.
        time_in = 13'b11_1111_111_1111;
        press_mode();
        check("invalid_cap", time_out, 13'b0);
        check("invalid_flag", edit_hour, 1'b1);
        do_clear();

        // Timeout in EDIT_MIN: returns to IDLE 20 cycles after entry, with no load.
        time_in   = 13'b00_1000_001_0101;   // 08:15
        load_base = load_count;
        press_mode();
        mode_btn = 1'b1; tick();            // entry edge into EDIT_MIN
        mode_btn = 1'b0;
        check("to_entry", edit_min, 1'b1);
        ticks(19);
        check("to_before", edit_min, 1'b1);
        tick();
        check("to_idle", {edit_hour, edit_min}, 2'b00);
        check("to_no_load", load_count - load_base, 0);
        check("to_keeps_time", time_out, 13'b00_1000_001_0101);

        // Clear in the middle of EDIT_HOUR
        time_in   = 13'b01_0010_011_0100;
        load_base = load_count;
        press_mode();
        press_inc(1);
        check("pre_clear", time_out, 13'b01_0011_011_0100);
        do_clear();
        check("midclr_flags", {edit_hour, edit_min}, 2'b00);
        check("midclr_time", time_out, 13'b0);
        check("midclr_no_load", load_count - load_base, 0);

        // Simultaneous mode and inc edges: mode wins, so the hours stay unchanged.
        time_in = 13'b01_0000_000_0000;     // 10:00
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1; tick();
        mode_btn = 1'b0; inc_btn = 1'b0; tick();
        check("simul_state", {edit_hour, edit_min}, 2'b01);
        check("simul_time", time_out, 13'b01_0000_000_0000);
        do_clear();

        // inc held for 15 cycles from 10:00
        press_mode();
        inc_btn = 1'b1; ticks(15);
        inc_btn = 1'b0; tick();
`ifdef AUTO_REPEAT_EN
        check("hold_hours", time_out, 13'b01_0110_000_0000);
`else
        check("hold_hours", time_out, 13'b01_0001_000_0000);
`endif
        check("hold_state", edit_hour, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
